// File: rtl/reg_file.sv
// RV32I integer register file: 2 combinational read ports, 1 synchronous write port, x0 tied to zero.
// Optional write-first bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREG = 2 ** ADDR_W;

  // Index 0 is deliberately absent: x0 has no storage.
  logic [WIDTH-1:0] regs [1:NREG-1];
  logic [CNT_W-1:0] count;
  logic             commit;

  assign commit   = we && (rd_addr != '0);
  assign wr_count = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
      count <= '0;
    end else if (commit) begin
      regs[rd_addr] <= wr_data;
      count         <= count + CNT_W'(1);
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = regs[rs1_addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (rst_n && commit && (rs1_addr == rd_addr)) begin
      rs1_data = wr_data;
    end
`endif
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      rs2_data = regs[rs2_addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (rst_n && commit && (rs2_addr == rd_addr)) begin
      rs2_data = wr_data;
    end
`endif
  end

endmodule

// File: doc/reg_file.md
# reg_file

Integer register file for the single-cycle RV32I core: 32 × WIDTH architectural registers with two combinational read ports and one synchronous write port. It sits directly upstream and downstream of the ALU:
- rs1/rs2 read data drive the ALU operands, through the immediate mux on b.
- The writeback mux, which carries the ALU result, load data or PC+4, returns into the single write port.
- x0 is hardwired to zero.
- A committed-write counter is provided for bench and debug visibility.

## Interface
- WIDTH, 32, register data width in bits
- ADDR_W, 5, register index width; register count is 2**ADDR_W
- CNT_W, 32, width of the committed-write counter
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk
- we  input  1  write enable for the current instruction
- rd_addr  input  ADDR_W  destination register index
- wr_data  input  WIDTH  writeback value
- rs1_addr  input  ADDR_W  read port 1 index
- rs2_addr  input  ADDR_W  read port 2 index
- rs1_data  output  WIDTH  read port 1 data, combinational
- rs2_data  output  WIDTH  read port 2 data, combinational
- wr_count  output  CNT_W  number of committed writes to registers other than x0

## Operation
- **Storage:** registers 1 to 2**ADDR_W−1 are WIDTH-bit flops. Register 0 has no storage.
- **Write:** at a rising edge with rst_n=1, we=1 and rd_addr≠0, regs[rd_addr] ← wr_data and wr_count ← wr_count+1.
- **x0 write:** a write with rd_addr=0 is discarded and does not increment wr_count.
- **we=0:** no state change.
- **Read:** rsN_data = 0 when rsN_addr = 0; otherwise rsN_data = regs[rsN_addr] (see Configuration for same-cycle writes).
- **Dual read:** both ports may address the same register; both return the same value.
- **Counter:** wr_count wraps modulo 2**CNT_W. There is no saturation and no overflow flag.
- **Reset:** at a rising edge with rst_n=0, every register ← 0 and wr_count ← 0. A write presented in the same cycle is dropped; reset has priority over we.
- **Reset mid-stream:** an instruction whose writeback coincides with the reset edge does not commit. The first write after reset needs rst_n=1 at its edge.
- **Unknown inputs:** X or unknown values on rd_addr while we=0 have no effect on state.

## Timing
- **Read latency:** 0 cycles, purely combinational from rsN_addr and register state.
- **Write latency:** 1 edge. The value is visible on read ports after the rising edge where it commits.
- **Reset values:** every register 0, so rs1_data = rs2_data = 0 for any address. wr_count = 0.
- **Critical path:** read mux → ALU → writeback mux → wr_data. The register file adds no flop on this path.
- **Back-to-back writes:** one per cycle, every cycle, with no bubble. Writing the same rd in consecutive cycles keeps the last value.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** write-first bypass. When we=1, rd_addr≠0, rst_n=1 and rsN_addr=rd_addr in the same cycle, rsN_data = wr_data combinationally. This supports a later pipelined variant.
- **Undefined:** read-before-write. rsN_data returns the pre-edge register value; the new value appears after the edge. This is the single-cycle default.
- Either way, bypass never applies to x0 or while rst_n=0.

## Test plan
- **Reset:** hold rst_n=0 for 2 edges after writing x5=0xDEADBEEF → rs1_addr=5 reads 0x00000000 and wr_count=0.
- **Write/read:** write x1=0x00000010 and x2=0xFFFFFFF0 on consecutive edges; set rs1=1, rs2=2 → 0x00000010 and 0xFFFFFFF0, wr_count=2.
- **x0 immutability:** we=1, rd=0, wr_data=0x12345678 → rs1_addr=0 reads 0, wr_count unchanged.
- **Same-cycle read of written register:** x3 holds 0xA; write x3=0xB with rs1_addr=3 before the edge → 0xB with `REGFILE_BYPASS_EN`, 0xA without; 0xB after the edge in both builds.
- **Reset-vs-write collision:** rst_n=0, we=1, rd=7, wr_data=0x55 at the same edge → x7 reads 0, wr_count=0.
- **Counter wrap:** build with CNT_W=4 and perform 17 writes to x9 → wr_count=1; x9 holds the last data.
